// File: rtl/pwm_params_pkg.sv
// Shared parameters and channel-state type for the transducer drive path
// (pwm_preconditioner -> pwm_generator).
package pwm_params_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;

    // One channel's timing settings as passed between drive-path stages.
    typedef struct packed {
        logic [PWM_WIDTH-1:0] cycle;
        logic [PWM_WIDTH-1:0] left;
        logic [PWM_WIDTH-1:0] right;
        logic                 over;
    } pwm_chan_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: free-running period counter, double-buffered edge
// registers that swap only at a period wrap or SYNC, and a registered compare.
module pwm_channel
    import pwm_params_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_sync,
    input  logic [WIDTH-1:0] i_cycle,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic             i_over,
    output logic             o_pwm
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_t;

    logic [WIDTH-1:0] r_cycle_s;
    logic [WIDTH-1:0] r_left_s;
    logic [WIDTH-1:0] r_right_s;
    logic             r_over_s;
    logic             r_pending;

    logic [WIDTH-1:0] r_cycle_a;
    logic [WIDTH-1:0] r_left_a;
    logic [WIDTH-1:0] r_right_a;
    logic             r_over_a;

    logic             r_pwm;

    logic             w_live;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_after_left;
    logic             w_before_right;
    logic             w_hi;

    // A zero-length period wraps every clock, which pins t at 0.
    assign w_live         = (r_cycle_a != '0);
    assign w_wrap         = !w_live || (r_t == (r_cycle_a - ONE));
    assign w_boundary     = w_wrap || i_sync;

    assign w_after_left   = (r_left_a <= r_t);
    assign w_before_right = (r_t < r_right_a);
    assign w_hi           = r_over_a ? (w_after_left || w_before_right)
                                     : (w_after_left && w_before_right);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_t       <= '0;
            r_cycle_s <= '0;
            r_left_s  <= '0;
            r_right_s <= '0;
            r_over_s  <= 1'b0;
            r_pending <= 1'b0;
            r_cycle_a <= '0;
            r_left_a  <= '0;
            r_right_a <= '0;
            r_over_a  <= 1'b0;
            r_pwm     <= 1'b0;
        end else begin
            r_t   <= w_boundary ? '0 : (r_t + ONE);
            r_pwm <= w_hi && w_live;

            // Transfer takes the old staging values; a LOAD in the same
            // cycle overwrites staging below and keeps pending set.
            if (w_boundary && r_pending) begin
                r_cycle_a <= r_cycle_s;
                r_left_a  <= r_left_s;
                r_right_a <= r_right_s;
                r_over_a  <= r_over_s;
                r_pending <= 1'b0;
            end

            if (i_load) begin
                r_cycle_s <= i_cycle;
                r_left_s  <= i_left;
                r_right_s <= i_right;
                r_over_s  <= i_over;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_generator.sv
// Final drive stage: DEPTH independent PWM channels sharing LOAD/SYNC/RST.
module pwm_generator
    import pwm_params_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = PWM_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             SYNC,
    input  logic [WIDTH-1:0] CYCLE   [0:DEPTH-1],
    input  logic [WIDTH-1:0] LEFT    [0:DEPTH-1],
    input  logic [WIDTH-1:0] RIGHT   [0:DEPTH-1],
    input  logic             OVER    [0:DEPTH-1],
    output logic             PWM_OUT [0:DEPTH-1]
);

    for (genvar g = 0; g < DEPTH; g++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_load  (LOAD),
            .i_sync  (SYNC),
            .i_cycle (CYCLE[g]),
            .i_left  (LEFT[g]),
            .i_right (RIGHT[g]),
            .i_over  (OVER[g]),
            .o_pwm   (PWM_OUT[g])
        );
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: table of single-setting periods, hand-written
// LOAD/SYNC/RST timing sequences, and randomized traffic against a model.
module tb_pwm_generator;

    localparam int W   = 13;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] cycle_in [0:NCH-1];
    logic [W-1:0] left_in  [0:NCH-1];
    logic [W-1:0] right_in [0:NCH-1];
    logic         over_in  [0:NCH-1];
    logic         pwm_out  [0:NCH-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_generator #(
        .WIDTH (W),
        .DEPTH (NCH)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .LOAD    (load),
        .SYNC    (sync),
        .CYCLE   (cycle_in),
        .LEFT    (left_in),
        .RIGHT   (right_in),
        .OVER    (over_in),
        .PWM_OUT (pwm_out)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        int lft;
        int rgt;
        bit ovr;
    } cfg_t;

    cfg_t m_act   [NCH];
    cfg_t m_nxt   [NCH];
    bit   m_nxt_v [NCH];
    int   m_t     [NCH];
    bit   exp_out [NCH];

    // Is position t inside the pulse? The wrapped pulse is everything
    // outside the gap [right, left).
    function automatic bit pulse_at(cfg_t c, int t);
        if (c.cyc == 0) return 1'b0;
        if (!c.ovr) return (t >= c.lft) && (t < c.rgt);
        return !((t >= c.rgt) && (t < c.lft));
    endfunction

    initial begin
        for (int ch = 0; ch < NCH; ch++) begin
            m_act[ch]   = '{0, 0, 0, 1'b0};
            m_nxt[ch]   = '{0, 0, 0, 1'b0};
            m_nxt_v[ch] = 1'b0;
            m_t[ch]     = 0;
            exp_out[ch] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (rst) begin
                m_act[ch]   = '{0, 0, 0, 1'b0};
                m_nxt_v[ch] = 1'b0;
                m_t[ch]     = 0;
                exp_out[ch] = 1'b0;
            end else begin
                bit period_end;
                bit boundary;
                exp_out[ch] = pulse_at(m_act[ch], m_t[ch]);
                period_end  = (m_act[ch].cyc == 0) || (m_t[ch] + 1 == m_act[ch].cyc);
                boundary    = period_end || sync;
                if (boundary && m_nxt_v[ch]) begin
                    m_act[ch]   = m_nxt[ch];
                    m_nxt_v[ch] = 1'b0;
                end
                m_t[ch] = boundary ? 0 : m_t[ch] + 1;
                if (load) begin
                    m_nxt[ch]   = '{int'(cycle_in[ch]), int'(left_in[ch]),
                                    int'(right_in[ch]), over_in[ch]};
                    m_nxt_v[ch] = 1'b1;
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (pwm_out[ch] !== exp_out[ch]) begin
                n_errors++;
                if (n_errors <= 30)
                    $display("FAIL model ch%0d t=%0d: pwm=%b expected=%b",
                             ch, m_t[ch], pwm_out[ch], exp_out[ch]);
            end
        end
    endtask

    task automatic check_int(string name, int actual, int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_all(int c, int l, int r, bit o);
        for (int ch = 0; ch < NCH; ch++) begin
            cycle_in[ch] = W'(c);
            left_in[ch]  = W'(l);
            right_in[ch] = W'(r);
            over_in[ch]  = o;
        end
    endtask

    task automatic load_all(int c, int l, int r, bit o);
        set_all(c, l, r, o);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_int("reset_pwm", int'(pwm_out[0]), 0);
    endtask

    task automatic wait_t(int tv);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_t[0] == tv) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_t: t=%0d never reached, last t=%0d", tv, m_t[0]);
        end
    endtask

    // Counts high outputs over n clocks starting from the next t=0.
    task automatic count_period(int n, output int hi, output int first);
        hi    = 0;
        first = -1;
        wait_t(0);
        for (int k = 0; k < n; k++) begin
            tick();
            if (pwm_out[0] === 1'b1) begin
                if (first < 0) first = k;
                hi++;
            end
        end
    endtask

    // ---------------- test ----------------
    typedef struct {
        int cyc;
        int lft;
        int rgt;
        bit ovr;
        int win;
        int exp_hi;
        int exp_first;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int first;

        vecs[0] = '{100, 20, 70, 1'b0, 100,  50, 20};
        vecs[1] = '{100, 80, 30, 1'b1, 100,  50,  0};
        vecs[2] = '{100, 50, 50, 1'b0, 100,   0, -1};
        vecs[3] = '{100, 50, 50, 1'b1, 100, 100,  0};
        vecs[4] = '{  0, 10, 20, 1'b1,  20,   0, -1};
        vecs[5] = '{ 10, 12, 15, 1'b0,  10,   0, -1};
        vecs[6] = '{ 10,  3, 20, 1'b0,  10,   7,  3};
        vecs[7] = '{ 16, 14,  2, 1'b1,  16,   4,  0};

        set_all(0, 0, 0, 1'b0);
        tick();
        tick();
        do_reset();

        // Table: reset, one LOAD, then one full period from t=0.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_all(vecs[v].cyc, vecs[v].lft, vecs[v].rgt, vecs[v].ovr);
            tick();
            count_period(vecs[v].win, hi, first);
            check_int($sformatf("vec%0d_high", v), hi, vecs[v].exp_hi);
            check_int($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
        end

        // Mid-period LOAD: running 20/70, LOAD 40/60 at t=45.
        do_reset();
        load_all(100, 20, 70, 1'b0);
        wait_t(45);
        load_all(100, 40, 60, 1'b0);
        count_period(100, hi, first);
        check_int("midload_high", hi, 20);
        check_int("midload_first", first, 40);

        // LOAD at t=99 misses the current wrap.
        wait_t(10);
        load_all(100, 20, 70, 1'b0);
        count_period(100, hi, first);
        check_int("reload_high", hi, 50);
        wait_t(99);
        load_all(100, 40, 60, 1'b0);
        count_period(100, hi, first);
        check_int("load99_old_high", hi, 50);
        check_int("load99_old_first", first, 20);
        count_period(100, hi, first);
        check_int("load99_new_high", hi, 20);

        // Two LOADs in one period: the second wins.
        wait_t(10);
        load_all(100, 5, 15, 1'b0);
        wait_t(50);
        load_all(100, 60, 90, 1'b0);
        count_period(100, hi, first);
        check_int("twoload_high", hi, 30);
        check_int("twoload_first", first, 60);

        // SYNC at t=37 restarts the period and applies the pending LOAD.
        wait_t(20);
        load_all(100, 0, 50, 1'b0);
        wait_t(37);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        hi    = 0;
        first = -1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pwm_out[0] === 1'b1) begin
                if (first < 0) first = k;
                hi++;
            end
        end
        check_int("sync_high", hi, 50);
        check_int("sync_first", first, 0);

        // RST mid-pulse: output drops next clock and stays low without LOAD.
        wait_t(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_int("rst_pwm", int'(pwm_out[0]), 0);
        hi = 0;
        for (int k = 0; k < 150; k++) begin
            tick();
            if (pwm_out[0] === 1'b1) hi++;
        end
        check_int("rst_stays_low", hi, 0);

        // Randomized traffic, independent settings per channel.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 11) == 0);
            sync = ($urandom_range(0, 149) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            if (load) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    int c;
                    c = $urandom_range(0, 40);
                    cycle_in[ch] = W'(c);
                    left_in[ch]  = W'($urandom_range(0, c + 3));
                    right_in[ch] = W'($urandom_range(0, c + 3));
                    over_in[ch]  = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end
        load = 1'b0;
        sync = 1'b0;
        rst  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
